// File: rtl/pack_bit.sv
// Packs a stream of 4-bit decoded nibbles, first nibble in the top bits, into 4*DEPTH-bit words.
// Each word is staged in an assembly register, then moved to an output register.
module pack_bit #(
    parameter int DEPTH = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_pack,
    input  logic [3:0]           i_Rx,
    input  logic                 i_flush,
    input  logic                 i_ready,
    output logic                 o_ready,
    output logic [4*DEPTH-1:0]   o_data,
    output logic                 o_valid,
    output logic [3:0]           o_len,
    output logic                 o_overflow,
    output logic                 dbg_hold
);

    localparam int W  = 4 * DEPTH;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    asm_q;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic [CW-1:0]   cnt_next;
    logic [W-1:0]    asm_next;
    logic [W-1:0]    nib_word;
    logic            word_done;
    logic            out_free;

    // Handshakes: a nibble moves on a rising edge with en_pack && o_ready; a word
    // leaves on a rising edge with o_valid && i_ready. Neither side may retract.
    assign o_ready  = (state == FILL);
    assign dbg_hold = (state == HOLD);

    always_comb begin
        accept    = en_pack && (state == FILL);
        cnt_next  = cnt + CW'(accept);
        nib_word  = {i_Rx, {(W-4){1'b0}}};
        asm_next  = asm_q;
        if (accept) begin
            asm_next = asm_q | (nib_word >> {cnt, 2'b00});
        end
        // A flush counts the nibble accepted on the same edge.
        word_done = (state == FILL) &&
                    ((cnt_next == CW'(DEPTH)) || (i_flush && (cnt_next != '0)));
        out_free  = !o_valid || i_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            asm_q      <= '0;
            cnt        <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_len      <= 4'd0;
            o_overflow <= 1'b0;
        end else begin
            if (en_pack && (state == HOLD)) begin
                o_overflow <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (word_done && out_free) begin
                        o_data  <= asm_next;
                        o_len   <= 4'(cnt_next);
                        o_valid <= 1'b1;
                        asm_q   <= '0;
                        cnt     <= '0;
                    end else begin
                        asm_q <= asm_next;
                        cnt   <= cnt_next;
                        if (word_done) begin
                            state <= HOLD;
                        end else if (o_valid && i_ready) begin
                            o_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // Only reachable with OUT occupied, so out_free means it is being consumed.
                    if (out_free) begin
                        o_data  <= asm_q;
                        o_len   <= 4'(cnt);
                        o_valid <= 1'b1;
                        asm_q   <= '0;
                        cnt     <= '0;
                        state   <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pack_bit.sv
// Self-checking bench for pack_bit: directed scenarios plus random traffic against a
// queue-based word model.
module tb_pack_bit;

    localparam int DEPTH = 15;
    localparam int W     = 4 * DEPTH;

    logic           clk;
    logic           rst;
    logic           en_pack;
    logic [3:0]     i_Rx;
    logic           i_flush;
    logic           i_ready;
    logic           o_ready;
    logic [W-1:0]   o_data;
    logic           o_valid;
    logic [3:0]     o_len;
    logic           o_overflow;
    logic           dbg_hold;

    int total = 0;
    int bad   = 0;

    // Reference model: nibbles of the word being built, a pending-complete flag, and OUT.
    int             cur_q[$];
    logic           m_pend;
    logic           m_valid;
    logic           m_ovf;
    logic [W-1:0]   m_data;
    logic [3:0]     m_len;

    pack_bit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_pack    (en_pack),
        .i_Rx       (i_Rx),
        .i_flush    (i_flush),
        .i_ready    (i_ready),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_len      (o_len),
        .o_overflow (o_overflow),
        .dbg_hold   (dbg_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] word;
        word = '0;
        foreach (cur_q[i]) begin
            word = word | (W'(cur_q[i]) << (4 * (DEPTH - 1 - i)));
        end
        return word;
    endfunction

    task automatic model_reset();
        cur_q.delete();
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_data  = '0;
        m_len   = 4'd0;
    endtask

    task automatic move_to_out();
        m_data  = pack_word();
        m_len   = 4'(cur_q.size());
        m_valid = 1'b1;
        cur_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
        chk({tag, ".data"},  64'(o_data),  64'(m_data));
        chk({tag, ".len"},   64'(o_len),   64'(m_len));
        chk({tag, ".ovf"},   64'(o_overflow), 64'(m_ovf));
        chk({tag, ".ready"}, 64'(o_ready), 64'(!m_pend));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check 1ns later.
    task automatic cycle(input logic en, input logic [3:0] nib, input logic fl, input logic rdy,
                         input string tag);
        logic free;
        en_pack = en;
        i_Rx    = nib;
        i_flush = fl;
        i_ready = rdy;
        chk({tag, ".pre_ready"}, 64'(o_ready), 64'(!m_pend));
        @(posedge clk);
        free = !m_valid || rdy;
        if (!m_pend) begin
            if (en) cur_q.push_back(int'(nib));
            if ((cur_q.size() == DEPTH) || (fl && cur_q.size() > 0)) begin
                if (free) move_to_out();
                else m_pend = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end else begin
            if (en) m_ovf = 1'b1;
            if (free) begin
                move_to_out();
                m_pend = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
        en_pack = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".data0"},  64'(o_data), 64'(0));
        chk({tag, ".valid0"}, 64'(o_valid), 64'(0));
        chk({tag, ".len0"},   64'(o_len), 64'(0));
        chk({tag, ".ovf0"},   64'(o_overflow), 64'(0));
        chk({tag, ".ready0"}, 64'(o_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        en_pack = 1'b0;
        i_Rx    = 4'h0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;

        // Fifteen nibbles 1..F with downstream ready form one word on the last accept.
        for (int k = 1; k <= DEPTH; k++) cycle(1'b1, 4'(k), 1'b0, 1'b1, "seq");
        chk("seq.word", 64'(o_data), 64'h0123456789ABCDEF);
        chk("seq.len", 64'(o_len), 64'd15);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "seq_drain");

        // Downstream stalled: second word waits in HOLD, extra nibble overflows.
        for (int k = 0; k < 2 * DEPTH; k++) cycle(1'b1, 4'hA, 1'b0, 1'b0, "stall");
        chk("stall.hold", 64'(o_ready), 64'd0);
        cycle(1'b1, 4'h5, 1'b0, 1'b0, "stall_ovf");
        chk("stall.ovf", 64'(o_overflow), 64'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "stall_release");
        chk("stall.word2", 64'(o_data), 64'h0AAAAAAAAAAAAAAA);
        chk("stall.valid2", 64'(o_valid), 64'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "stall_drain");

        // Partial word flush, then a flush with nothing buffered.
        cycle(1'b1, 4'hF, 1'b0, 1'b1, "fl");
        cycle(1'b1, 4'hE, 1'b0, 1'b1, "fl");
        cycle(1'b1, 4'hD, 1'b0, 1'b1, "fl");
        cycle(1'b0, 4'h0, 1'b1, 1'b0, "fl_go");
        chk("fl.word", 64'(o_data), 64'h0FED000000000000);
        chk("fl.len", 64'(o_len), 64'd3);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "fl_drain");
        cycle(1'b0, 4'h0, 1'b1, 1'b1, "fl_empty");
        chk("fl_empty.valid", 64'(o_valid), 64'd0);
        cycle(1'b1, 4'h7, 1'b1, 1'b1, "fl_one");
        chk("fl_one.len", 64'(o_len), 64'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "fl_one_drain");

        // Final nibble lands on the same edge the previous word is consumed.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 4'h3, 1'b0, 1'b0, "b2b_a");
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 4'(k), 1'b0, (k == DEPTH - 1), "b2b_b");
        chk("b2b.valid", 64'(o_valid), 64'd1);
        chk("b2b.word", 64'(o_data), 64'h00123456789ABCDE);
        chk("b2b.ready", 64'(o_ready), 64'd1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "b2b_drain");

        // Reset mid-word and in HOLD, then a clean word.
        for (int k = 0; k < 7; k++) cycle(1'b1, 4'h9, 1'b0, 1'b1, "rst_mid");
        async_reset("rst_mid");
        for (int k = 0; k < 2 * DEPTH; k++) cycle(1'b1, 4'h6, 1'b0, 1'b0, "rst_hold");
        chk("rst_hold.in_hold", 64'(dbg_hold), 64'd1);
        async_reset("rst_hold");
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 4'(15 - k), 1'b0, 1'b1, "rst_clean");
        chk("rst_clean.word", 64'(o_data), 64'h0FEDCBA987654321);

        // Random traffic: a busy-downstream phase then a mostly-ready phase.
        async_reset("rand_start");
        for (int k = 0; k < 300; k++)
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0, "rand_slow");
        for (int k = 0; k < 300; k++)
            cycle($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0, "rand_fast");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pack_bit.md
PACK_BIT -- requirements
Module: pack_bit

Interface
REQ-001 Parameter DEPTH, default 15, sets nibbles per output word; word width is 4*DEPTH (60 at default).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; the only reset.
REQ-004 en_pack  input  1  nibble valid; i_Rx is accepted on a rising edge where en_pack=1 and o_ready=1.
REQ-005 i_Rx  input  4  radix-4 decoded nibble, bit 3 is the earliest decoded bit.
REQ-006 i_flush  input  1  one-cycle request to emit a partially filled word.
REQ-007 i_ready  input  1  downstream accepts o_data on a rising edge where o_valid=1 and i_ready=1.
REQ-008 o_ready  output  1  block can accept a nibble this cycle.
REQ-009 o_data  output  4*DEPTH  packed word, first nibble in bits [4*DEPTH-1:4*DEPTH-4].
REQ-010 o_valid  output  1  o_data holds an unconsumed word.
REQ-011 o_len  output  4  number of valid nibbles in o_data (1..DEPTH).
REQ-012 o_overflow  output  1  sticky; set when en_pack=1 while o_ready=0.

Function
REQ-013 Datapath: assembly register (ASM), nibble counter cnt (0..DEPTH), output register (OUT); OUT drives o_data/o_len directly.
REQ-014 Accepted nibble k (k=0 first) is written to ASM bits [4*DEPTH-1-4k : 4*DEPTH-4-4k]; cnt increments by 1.
REQ-015 FSM states: FILL (cnt<DEPTH, accepting), HOLD (ASM complete or flushed, waiting for OUT to free); reset state FILL.
REQ-016 o_ready=1 in FILL, 0 in HOLD; combinational from state only.
REQ-017 Word complete: when the accepted nibble makes cnt=DEPTH, the word transfers ASM->OUT on the same edge if OUT is empty or being consumed that edge; else FSM enters HOLD.
REQ-018 On transfer: o_valid<=1, o_len<=cnt value after the accept, ASM<=0, cnt<=0, FSM stays/returns to FILL.
REQ-019 In HOLD, transfer occurs on the first edge where OUT is empty or consumed (o_valid=1 and i_ready=1); FSM returns to FILL on that edge.
REQ-020 Word latency: o_valid rises on the edge that accepts the final nibble, when OUT is free (zero-cycle from final accept).
REQ-021 Consumption: o_valid=1 and i_ready=1 with no simultaneous transfer -> o_valid<=0, o_data held unchanged.
REQ-022 Flush with cnt>0 (counting a nibble accepted that same edge): treated as word complete; unfilled low nibbles are 0; o_len=cnt.
REQ-023 Flush with cnt=0 and no nibble accepted: ignored, no word emitted.
REQ-024 Flush in HOLD: ignored (word already pending).
REQ-025 Simultaneous transfer and consumption: OUT takes the new word, o_valid stays 1.
REQ-026 en_pack=1 while o_ready=0: nibble dropped, ASM/cnt unchanged, o_overflow<=1 until reset.
REQ-027 en_pack=0: ASM, cnt unchanged; no bubble penalty between nibbles.

Reset
REQ-028 rst=0 at any time, including mid-word or in HOLD: immediately FSM=FILL, cnt=0, ASM=0, o_data=0, o_valid=0, o_len=0, o_overflow=0; partial words discarded.
REQ-029 First accepted nibble after rst release is nibble 0 of a new word.

Verification
REQ-030 i_ready=1, 15 consecutive nibbles 0x1..0xF -> one o_valid pulse, o_data=0x123456789ABCDEF, o_len=15, on edge of 15th accept.
REQ-031 i_ready=0, 30 nibbles of 0xA -> first word in OUT; after 15 more ASM full, o_ready=0 (HOLD); nibble 31 sets o_overflow=1; raise i_ready -> second word of all 0xA transfers same edge first is consumed.
REQ-032 Nibbles 0xF,0xE,0xD then i_flush -> o_data=0xFED000000000000, o_len=3; i_flush with cnt=0 -> no o_valid.
REQ-033 Nibble 15 accepted on same edge i_ready consumes previous word -> o_valid stays 1, o_data shows new word, no stall.
REQ-034 rst asserted after 7 nibbles and in HOLD -> all outputs 0 asynchronously; next 15 nibbles form a clean word starting at bits [59:56].
